// File: rtl/csa_pkg.sv
// Shared widths, helpers and state encoding for the CSA partial-sum accumulator.
package csa_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int in_w(input int w, input int e);
    return w + e + 1;
  endfunction

  function automatic int acc_w(input int w, input int e, input int c);
    return in_w(w, e) + clog2(c);
  endfunction

endpackage

// File: rtl/csa_requant.sv
// Combinational requantiser: logical right shift, then clamp to the unsigned output range.
module csa_requant #(
  parameter int ACC_W = 11,
  parameter int SHIFT = 2,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] sum,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam int EXT_W = ACC_W + OUT_W;

  // Widening before the compare keeps it valid whether ACC_W is above or below OUT_W.
  function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] s);
    logic [EXT_W-1:0] q;
    q = EXT_W'(s >> SHIFT);
    if (q > EXT_W'({OUT_W{1'b1}})) return {1'b1, {OUT_W{1'b1}}};
    return {1'b0, q[OUT_W-1:0]};
  endfunction

  assign {sat, data} = requant(sum);

endmodule

// File: rtl/csa_sum_accumulator.sv
// Accumulates C partial sums per frame and presents one requantised result
// through a ready/valid output held stable until the consumer takes it.
module csa_sum_accumulator
  import csa_pkg::*;
#(
  parameter int N     = 49,
  parameter int E     = 4,
  parameter int W     = 4,
  parameter int C     = 4,
  parameter int SHIFT = 2,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [in_w(W, E)-1:0]  in_sum,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clear,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IN_W  = in_w(W, E);
  localparam int ACC_W = acc_w(W, E, C);
  localparam int CNT_W = (clog2(C) > 0) ? clog2(C) : 1;

  if (C < 1) begin : g_bad_c
    $error("csa_sum_accumulator: C must be at least 1");
  end
  if (N < 1) begin : g_bad_n
    $error("csa_sum_accumulator: N must be at least 1");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               last_beat;
  logic [ACC_W-1:0]   sum_full;
  logic [OUT_W-1:0]   rq_data;
  logic               rq_sat;

  assign in_ready  = (state_q == ST_ACC) || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(C - 1));
  // Beat 0 loads rather than adds, so acc_q never needs clearing between frames.
  assign sum_full  = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(in_sum);

  csa_requant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_requant (
    .sum  (sum_full),
    .data (rq_data),
    .sat  (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    if (state_q == ST_HOLD && out_ready) begin
      state_d     = ST_ACC;
      out_valid_d = 1'b0;
    end

    // Clear only aborts the frame in progress; a pending result is left alone.
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last_beat) begin
        out_data_d  = rq_data;
        out_sat_d   = rq_sat;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
        cnt_d       = '0;
      end else begin
        acc_d = sum_full;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa_sum_accumulator.sv
// Directed, table-driven bench for csa_sum_accumulator at default parameters.
module tb_csa_sum_accumulator;

  localparam int IN_W  = 9;
  localparam int OUT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  in_sum;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  int checks;
  int errors;

  csa_sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sum    (in_sum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][IN_W-1:0] b;
    logic [OUT_W-1:0]     exp_data;
    logic                 exp_sat;
  } frame_t;

  frame_t vec[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats with out_ready high, then one retire cycle.
  task automatic run_frame(input int idx);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sum   = vec[idx].b[k];
      if (k == 3) chk($sformatf("v%0d_no_early_valid", idx), 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("v%0d_data", idx), 32'(out_data), 32'(vec[idx].exp_data));
    chk($sformatf("v%0d_sat", idx), 32'(out_sat), 32'(vec[idx].exp_sat));
    tick();
    chk($sformatf("v%0d_retired", idx), 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vec[0].b = {9'd40, 9'd30, 9'd20, 9'd10};    vec[0].exp_data = 8'd25;  vec[0].exp_sat = 1'b0;
    // 511 is the largest in_sum at IN_W=9; 2044>>2 = 511 clamps.
    vec[1].b = {9'd511, 9'd511, 9'd511, 9'd511}; vec[1].exp_data = 8'd255; vec[1].exp_sat = 1'b1;
    vec[2].b = {9'd0, 9'd0, 9'd0, 9'd0};         vec[2].exp_data = 8'd0;   vec[2].exp_sat = 1'b0;
    vec[3].b = {9'd1, 9'd1, 9'd1, 9'd1};         vec[3].exp_data = 8'd1;   vec[3].exp_sat = 1'b0;
    vec[4].b = {9'd0, 9'd0, 9'd0, 9'd3};         vec[4].exp_data = 8'd0;   vec[4].exp_sat = 1'b0;
    vec[5].b = {9'd255, 9'd255, 9'd255, 9'd255}; vec[5].exp_data = 8'd255; vec[5].exp_sat = 1'b0;
    vec[6].b = {9'd256, 9'd256, 9'd256, 9'd256}; vec[6].exp_data = 8'd255; vec[6].exp_sat = 1'b1;
    vec[7].b = {9'd7, 9'd100, 9'd200, 9'd300};   vec[7].exp_data = 8'd151; vec[7].exp_sat = 1'b0;

    rst_n     = 1'b0;
    in_sum    = '0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data", 32'(out_data), 32'd0);
    chk("idle_sat", 32'(out_sat), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_frame(i);

    // Result held while the consumer stalls; beats offered meanwhile are refused.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sum   = 9'(10 * (k + 1));
      tick();
    end
    in_sum = 9'd100;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("hold%0d_in_ready", s), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_valid", s), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_data", s), 32'(out_data), 32'd25);
      tick();
    end
    out_ready = 1'b1;
    in_sum    = 9'd4;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_retired", 32'(out_valid), 32'd0);
    tick();
    tick();
    chk("release_no_early", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_data", 32'(out_data), 32'd4);
    tick();

    // Clear aborts a partial frame and wins over a simultaneous beat.
    in_valid = 1'b1; in_sum = 9'd1; tick();
    in_sum = 9'd2; tick();
    clear = 1'b1; in_sum = 9'd200; tick();
    clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sum = 9'd4; tick();
      in_valid = 1'b0;
      if (k < 3) chk($sformatf("clr_gap%0d_valid", k), 32'(out_valid), 32'd0);
      if (k < 3) tick();
    end
    chk("clr_valid", 32'(out_valid), 32'd1);
    chk("clr_data", 32'(out_data), 32'd4);
    tick();
    chk("clr_retired", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-frame discards the partial sum.
    in_valid = 1'b1; in_sum = 9'd5;
    tick(); tick(); tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sum = 9'd8; tick();
    end
    in_valid = 1'b0;
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'd8);
    chk("post_rst_sat", 32'(out_sat), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
